// File: rtl/mvau_thresh_act.sv
// mvau_thresh_act: multi-threshold activation; each lane outputs how many of its fold's thresholds the accumulator meets.
// Two-stage pipeline: S1 registers accumulators plus the fold's threshold set, S2 compares and popcounts.
module mvau_thresh_act #(
  parameter int PE = 2,
  parameter int NF = 4,
  parameter int TA = 16,
  parameter int TDstI = 2,
  localparam int N_THR = 2**TDstI - 1,
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1,
  localparam int PEW = (PE > 1) ? $clog2(PE) : 1,
  localparam int IW = (N_THR > 1) ? $clog2(N_THR) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_v,
  input  logic [PE*TA-1:0]      i_in,
  input  logic                  i_thr_we,
  input  logic [NFW-1:0]        i_thr_nf,
  input  logic [PEW-1:0]        i_thr_pe,
  input  logic [IW-1:0]         i_thr_idx,
  input  logic signed [TA-1:0]  i_thr_data,
  output logic                  o_out_v,
  output logic [PE*TDstI-1:0]   o_out
);
  logic [NFW-1:0] r_nf_cnt;
  logic r_v1;
  logic [PE*TA-1:0] r_acc;
  logic signed [TA-1:0] r_thr [NF][PE][N_THR];
  logic signed [TA-1:0] r_thr1 [PE][N_THR];
  logic [PE*TDstI-1:0] w_out;
  logic w_we_ok;
  assign w_we_ok = i_thr_we && (32'(i_thr_nf) < NF) && (32'(i_thr_pe) < PE) && (32'(i_thr_idx) < N_THR);
  // RAM is never reset; a read in the same cycle as a write sees the old value via NBA ordering
  always_ff @(posedge clk) begin
    if (w_we_ok) r_thr[i_thr_nf][i_thr_pe][i_thr_idx] <= i_thr_data;
    if (i_in_v) begin
      r_acc <= i_in;
      r_thr1 <= r_thr[r_nf_cnt];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nf_cnt <= '0;
      r_v1 <= 1'b0;
      o_out_v <= 1'b0;
      o_out <= '0;
    end else begin
      r_v1 <= i_in_v;
      o_out_v <= r_v1;
      if (i_in_v) r_nf_cnt <= (32'(r_nf_cnt) == NF - 1) ? '0 : r_nf_cnt + NFW'(1);
      if (r_v1) o_out <= w_out;
    end
  end
  always_comb begin
    w_out = '0;
    for (int p = 0; p < PE; p++)
      for (int i = 0; i < N_THR; i++)
        w_out[p*TDstI +: TDstI] = w_out[p*TDstI +: TDstI] + TDstI'($signed(r_acc[p*TA +: TA]) >= r_thr1[p][i]);
  end
endmodule

// File: tb/tb_mvau_thresh_act.sv
// tb_mvau_thresh_act: table vectors plus scoreboard-checked sequences for fold rotation, gaps, reset and RAM collision.
module tb_mvau_thresh_act;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_v = 1'b0;
  logic [31:0] in_w = '0;
  logic thr_we = 1'b0;
  logic [1:0] thr_nf = '0, thr_pe_w = '0, thr_idx = '0;
  logic [0:0] thr_pe;
  logic signed [15:0] thr_data = '0;
  logic out_v;
  logic [3:0] out_w;
  assign thr_pe = thr_pe_w[0];

  mvau_thresh_act #(.PE(2), .NF(4), .TA(16), .TDstI(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_v(in_v), .i_in(in_w),
    .i_thr_we(thr_we), .i_thr_nf(thr_nf), .i_thr_pe(thr_pe), .i_thr_idx(thr_idx),
    .i_thr_data(thr_data), .o_out_v(out_v), .o_out(out_w)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] val; int cyc; } exp_t;
  typedef struct { logic signed [15:0] a0, a1; logic [1:0] e0, e1; } vec_t;
  exp_t sb[$];
  vec_t tab[7];
  logic signed [15:0] m_thr [4][2][3];
  int m_nf = 0;
  int cyc = 0;
  int checks = 0, errors = 0;
  logic rst_q = 1'b0;
  logic [3:0] m_last = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= rst_n;
  end

  function automatic logic [3:0] model(input logic signed [15:0] a0, a1, input int f);
    logic [1:0] c0 = '0, c1 = '0;
    for (int i = 0; i < 3; i++) begin
      if (a0 >= m_thr[f][0][i]) c0 = c0 + 2'd1;
      if (a1 >= m_thr[f][1][i]) c1 = c1 + 2'd1;
    end
    return {c1, c0};
  endfunction

  // Drive one cycle of inputs; expectations are queued with their arrival cycle.
  task automatic step(input bit v, input logic signed [15:0] a0, a1, input bit we, input int wnf, wpe, widx,
                      input logic signed [15:0] wd, input bit tab_en, input logic [3:0] tab_exp);
    exp_t e;
    @(posedge clk); #1;
    in_v = v; in_w = {a1, a0};
    thr_we = we; thr_nf = 2'(wnf); thr_pe_w = 2'(wpe); thr_idx = 2'(widx); thr_data = wd;
    if (v) begin
      e.val = tab_en ? tab_exp : model(a0, a1, m_nf);
      e.cyc = cyc + 2;
      sb.push_back(e);
      m_nf = (m_nf + 1) % 4;
    end
    if (we && widx < 3) m_thr[wnf][wpe][widx] = wd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic word(input logic signed [15:0] a0, a1);
    step(1, a0, a1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int f, p, i, input logic signed [15:0] d);
    step(0, 0, 0, 1, f, p, i, d, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_v = 1'b0; thr_we = 1'b0;
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    m_nf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_out: no out_v at cycle %0d, expected out=%h", e.cyc, e.val);
    end
    if (!rst_q) begin
      checks++;
      if (out_v !== 1'b0 || out_w !== 4'h0) begin
        errors++;
        $display("FAIL reset_state: out_v=%b out=%h, required out_v=0 out=0", out_v, out_w);
      end
      m_last = '0;
    end else if (out_v === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: out_v=1 out=%h at cycle %0d with nothing expected", out_w, cyc);
      end else begin
        e = sb.pop_front();
        if (out_w !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL out_word: out=%h at cycle %0d, required out=%h at cycle %0d", out_w, cyc, e.val, e.cyc);
        end
      end
      m_last = out_w;
    end else begin
      checks++;
      if (out_v !== 1'b0 || out_w !== m_last) begin
        errors++;
        $display("FAIL out_hold: out_v=%b out=%h, required out_v=0 out=%h", out_v, out_w, m_last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{16'sd0, 16'sd0, 2'd2, 2'd2};
    tab[1] = '{-16'sd6, -16'sd1, 2'd0, 2'd1};
    tab[2] = '{-16'sd5, 16'sd32767, 2'd1, 2'd3};
    tab[3] = '{16'sd10, -16'sd32768, 2'd3, 2'd1};
    tab[4] = '{16'sd32767, 16'sd5, 2'd3, 2'd2};
    tab[5] = '{-16'sd32768, 16'sd32766, 2'd0, 2'd2};
    tab[6] = '{16'sd9, 16'sd0, 2'd2, 2'd2};
    idle(2);
    rst_n = 1'b1;
    // every fold gets lane0 {-5,0,10} and lane1 {-32768,32767,0}
    for (int f = 0; f < 4; f++) begin
      wr(f, 0, 0, -16'sd5); wr(f, 0, 1, 16'sd0); wr(f, 0, 2, 16'sd10);
      wr(f, 1, 0, -16'sd32768); wr(f, 1, 1, 16'sd32767); wr(f, 1, 2, 16'sd0);
    end
    for (int k = 0; k < 7; k++)
      step(1, tab[k].a0, tab[k].a1, 0, 0, 0, 0, 0, 1, {tab[k].e1, tab[k].e0});
    idle(3);
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < 3; i++) wr(f, p, i, 16'(f*20 + p*7 + i*9 - 30));
    wr(2, 0, 3, 16'sd999);
    for (int k = 0; k < 8; k++) word(16'($urandom_range(0, 120)) - 16'sd60, 16'($urandom_range(0, 120)) - 16'sd60);
    idle(2);
    for (int k = 0; k < 6; k++) begin
      word(16'($urandom_range(0, 120)) - 16'sd60, 16'($urandom_range(0, 120)) - 16'sd60);
      idle(3);
    end
    word(16'sd40, 16'sd40);
    word(-16'sd40, 16'sd0);
    do_reset();
    word(-16'sd30, 16'sd0);
    idle(3);
    do_reset();
    word(16'sd0, 16'sd0);
    step(1, 16'sd50, 16'sd50, 1, 1, 1, 2, 16'sd100, 0, 0);
    word(16'sd50, 16'sd50);
    word(16'sd50, 16'sd50);
    word(16'sd50, 16'sd50);
    word(16'sd50, 16'sd50);
    for (int k = 0; k < 10 && sb.size() > 0; k++) idle(1);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never arrived, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
